// File: rtl/fir_vect_pkg.sv
// Shared constants for the vector FIR sequencer.
// ALU opcodes driven on alu_ctrl and the sequencer state encoding.
package fir_vect_pkg;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_SRLI = 4'b0011;
  localparam logic [3:0] ALU_SLLI = 4'b0100;
  localparam logic [3:0] ALU_SARI = 4'b0101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MUL,
    ST_ACC,
    ST_OUT
  } fir_state_t;

endpackage

// File: rtl/sat_add_vect.sv
// Lane-wise signed saturating add of two packed M x N vectors.
// Ports: a, b in (M*N); s out (M*N). Purely combinational.
module sat_add_vect #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic [M*N-1:0] a,
  input  logic [M*N-1:0] b,
  output logic [M*N-1:0] s
);

  localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

  logic [N:0] sum;

  always_comb begin
    s   = '0;
    sum = '0;
    for (int i = 0; i < M; i++) begin
      sum = {a[i*N+N-1], a[i*N +: N]}
          + {b[i*N+N-1], b[i*N +: N]};
      // top two bits disagree only on overflow;
      // bit N carries the true sign
      if (sum[N] != sum[N-1])
        s[i*N +: N] = sum[N] ? MINV : MAXV;
      else
        s[i*N +: N] = sum[N-1:0];
    end
  end

endmodule

// File: rtl/fir_vect_seq.sv
// Vector FIR block sequencer driving a shared vector ALU.
// Ports: start/taps/shamt in, buffer addr/data, alu a/b/ctrl/result,
// y/y_valid/y_ready output handshake, busy and done status.
module fir_vect_seq
  import fir_vect_pkg::*;
#(
  parameter int N  = 8,
  parameter int M  = 4,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [TW-1:0] taps,
  input  logic [N-1:0]  shamt,
  output logic          busy,
  output logic          done,
  output logic [TW-1:0] x_addr,
  output logic [TW-1:0] h_addr,
  input  logic [M*N-1:0] x_data,
  input  logic [M*N-1:0] h_data,
  output logic [M*N-1:0] alu_a,
  output logic [M*N-1:0] alu_b,
  output logic [3:0]     alu_ctrl,
  input  logic [M*N-1:0] alu_result,
  output logic [M*N-1:0] y,
  output logic           y_valid,
  input  logic           y_ready
);

  localparam logic [TW-1:0] ONE = 1;

  fir_state_t     state;
  logic [TW-1:0]  k;
  logic [TW-1:0]  taps_r;
  logic [N-1:0]   shamt_r;
  logic [M*N-1:0] acc;
  logic [M*N-1:0] p;
  logic [M*N-1:0] acc_nxt;

  sat_add_vect #(
    .N(N),
    .M(M)
  ) u_sat (
    .a(acc),
    .b(alu_result),
    .s(acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      taps_r  <= '0;
      shamt_r <= '0;
      acc     <= '0;
      p       <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            taps_r  <= taps;
            shamt_r <= shamt;
            k       <= '0;
            acc     <= '0;
            p       <= '0;
            state   <= (taps == '0) ? ST_OUT
                                    : ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_MUL;
        ST_MUL: begin
          p     <= alu_result;
          state <= ST_ACC;
        end
        ST_ACC: begin
          acc   <= acc_nxt;
          k     <= k + ONE;
          state <= ((k + ONE) == taps_r) ? ST_OUT
                                         : ST_FETCH;
        end
        ST_OUT: begin
          if (y_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign y_valid = (state == ST_OUT);
  assign done    = y_valid & y_ready;
  assign y       = y_valid ? acc : '0;
  assign x_addr  = k;
  assign h_addr  = k;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_NOP;
    unique case (state)
      ST_MUL: begin
        alu_a    = x_data;
        alu_b    = h_data;
        alu_ctrl = ALU_MUL;
      end
      ST_ACC: begin
        alu_a    = p;
        alu_b    = {M{shamt_r}};
        alu_ctrl = ALU_SARI;
      end
      default: begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_NOP;
      end
    endcase
  end

endmodule

// File: tb/tb_fir_vect_seq.sv
// Scoreboard bench for fir_vect_seq with an ALU and buffer model.
// Expected blocks are queued by the driver and checked by a monitor.
module tb_fir_vect_seq;
  import fir_vect_pkg::*;

  localparam int N  = 8;
  localparam int M  = 4;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [TW-1:0] taps_i = '0;
  logic [N-1:0]  shamt_i = '0;
  logic busy, done, y_valid;
  logic y_ready = 1'b1;
  logic [TW-1:0] x_addr, h_addr;
  logic [M*N-1:0] x_data, h_data;
  logic [M*N-1:0] alu_a, alu_b, alu_result, y;
  logic [3:0] alu_ctrl;

  always #5 clk = ~clk;

  fir_vect_seq #(.N(N), .M(M), .TW(TW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .taps(taps_i), .shamt(shamt_i),
    .busy(busy), .done(done),
    .x_addr(x_addr), .h_addr(h_addr),
    .x_data(x_data), .h_data(h_data),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .y(y), .y_valid(y_valid), .y_ready(y_ready)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [M*N-1:0] xmem [16];
  logic [M*N-1:0] hmem [16];
  int xv [16][M];
  int hv [16][M];

  always @(posedge clk) begin
    x_data <= xmem[x_addr];
    h_data <= hmem[h_addr];
  end

  function automatic logic [M*N-1:0] alu_f(
    input logic [M*N-1:0] a,
    input logic [M*N-1:0] b,
    input logic [3:0] c);
    logic [M*N-1:0] r;
    logic signed [N-1:0] ai, bi, ri;
    r = '0;
    for (int i = 0; i < M; i++) begin
      ai = a[i*N +: N];
      bi = b[i*N +: N];
      ri = '0;
      if (c == ALU_MUL) ri = ai * bi;
      else if (c == ALU_SARI) ri = ai >>> bi;
      r[i*N +: N] = ri;
    end
    return r;
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);

  function automatic logic [M*N-1:0] ref_y(input int nt, input int sh);
    logic [M*N-1:0] r;
    int acc, pr, lo, hi;
    lo = -(1 << (N-1));
    hi = (1 << (N-1)) - 1;
    r = '0;
    for (int l = 0; l < M; l++) begin
      acc = 0;
      for (int k = 0; k < nt; k++) begin
        pr = (xv[k][l] * hv[k][l]) & ((1 << N) - 1);
        if (pr > hi) pr = pr - (1 << N);
        acc = acc + (pr >>> sh);
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
      end
      r[l*N +: N] = acc[N-1:0];
    end
    return r;
  endfunction

  typedef struct {
    logic [M*N-1:0] y;
    int lat;
    int t0;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  bit in_out = 0;
  logic [M*N-1:0] yhold;

  always @(negedge clk) begin
    if (rst) begin
      in_out = 0;
    end else begin
      if (y_valid && !in_out) begin
        in_out = 1;
        yhold = y;
        if (q.size() == 0) chk("unexpected_y_valid", 1, 0);
        else chk("latency", cyc - q[0].t0, q[0].lat);
      end else if (y_valid) begin
        chk("y_stable", y, yhold);
      end
      if (y_valid || done) chk("done", done, y_valid && y_ready);
      if (y_valid && y_ready) begin
        in_out = 0;
        if (q.size() > 0) begin
          chk("y", y, q[0].y);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic pack_mem;
    for (int k = 0; k < 16; k++)
      for (int l = 0; l < M; l++) begin
        xmem[k][l*N +: N] = xv[k][l][N-1:0];
        hmem[k][l*N +: N] = hv[k][l][N-1:0];
      end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_yvalid"}, y_valid, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_ctrl"}, alu_ctrl, 0);
    chk({tag, "_addr"}, {x_addr, h_addr}, 0);
  endtask

  // stall < 0: y_ready stays high; otherwise held low for stall
  // cycles after y_valid while start is pulsed
  task automatic run_block(input int nt, input int sh, input int stall);
    int n;
    pack_mem();
    q.push_back('{ref_y(nt, sh), 1 + 3*nt, cyc});
    y_ready = (stall < 0);
    start = 1;
    taps_i = nt[TW-1:0];
    shamt_i = sh[N-1:0];
    tick();
    start = 0;
    taps_i = TW'($urandom);
    shamt_i = N'($urandom);
    n = 0;
    if (stall >= 0) begin
      while (!y_valid && n < 200) begin
        if (nt == 0) chk("alu_ctrl_t0", alu_ctrl, 0);
        tick();
        n++;
      end
      if (!y_valid) begin
        chk("timeout", 1, 0);
        q.delete();
      end else begin
        repeat (stall) begin
          start = 1;
          tick();
          chk("busy_stall", busy, 1);
        end
        y_ready = 1;
        start = 1;
        tick();
        start = 0;
        chk("busy_after_out", busy, 0);
      end
    end else begin
      while (q.size() > 0 && n < 200) begin
        if (nt == 0) chk("alu_ctrl_t0", alu_ctrl, 0);
        tick();
        n++;
      end
      if (q.size() > 0) begin
        chk("timeout", 1, 0);
        q.delete();
      end
    end
    y_ready = 1;
    tick();
  endtask

  task automatic set_all(input int k0, input int xa[M], input int ha[M]);
    for (int l = 0; l < M; l++) begin
      xv[k0][l] = xa[l];
      hv[k0][l] = ha[l];
    end
  endtask

  task automatic scen1;
    set_all(0, '{10, 20, -30, 5}, '{2, 3, 4, -1});
  endtask

  initial begin
    int n;
    for (int k = 0; k < 16; k++)
      for (int l = 0; l < M; l++) begin
        xv[k][l] = 0;
        hv[k][l] = 0;
      end
    pack_mem();
    rst = 1;
    tick();
    tick();
    chk_idle("reset");
    rst = 0;
    tick();

    scen1();
    run_block(1, 0, -1);

    set_all(0, '{16, 16, 16, 16}, '{4, 4, 4, 4});
    set_all(1, '{16, 16, 16, 16}, '{4, 4, 4, 4});
    run_block(2, 1, -1);

    for (int k = 0; k < 3; k++)
      set_all(k, '{100, -100, 50, 0}, '{1, 1, 1, 1});
    run_block(3, 0, -1);

    scen1();
    run_block(1, 0, 5);

    scen1();
    pack_mem();
    start = 1;
    taps_i = 1;
    shamt_i = 0;
    tick();
    start = 0;
    n = 0;
    while (alu_ctrl != ALU_MUL && n < 20) begin
      tick();
      n++;
    end
    chk("reached_mul", alu_ctrl, ALU_MUL);
    rst = 1;
    tick();
    rst = 0;
    chk_idle("midrst");
    tick();
    run_block(1, 0, -1);

    run_block(0, 3, -1);

    for (int it = 0; it < 20; it++) begin
      int nt, sh;
      nt = $urandom_range(0, 6);
      sh = $urandom_range(0, N-1);
      for (int k = 0; k < 16; k++)
        for (int l = 0; l < M; l++) begin
          xv[k][l] = $urandom_range(0, 255) - 128;
          hv[k][l] = $urandom_range(0, 255) - 128;
        end
      run_block(nt, sh, $urandom_range(0, 3) - 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_vect_seq.md
# fir_vect_seq

Sequencer that runs one block of a vector FIR on the shared vector ALU (`alu_vect`, N-bit elements, M lanes). For each tap it fetches a sample vector and a coefficient vector, issues MUL and then SARI scaling on the ALU, and accumulates the scaled products per lane with saturation. It sits between the sample/coefficient buffers and the output stream, and owns the ALU `a`/`b`/`ctrl` inputs while busy.

## Interface
- `N`, 8: element width in bits; must match `alu_vect`.
- `M`, 4: lanes per vector; must match `alu_vect`.
- `TW`, 4: tap-count width; up to 2^TW-1 taps per block.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a block; sampled only in IDLE.
- `taps` in TW: number of taps; sampled with `start`.
- `shamt` in N: arithmetic right-shift amount, broadcast to all lanes; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on the output transfer cycle.
- `x_addr` / `h_addr` out TW: sample and coefficient buffer read address (tap index k).
- `x_data` / `h_data` in M×N signed: buffer read data, valid exactly one cycle after the address is driven.
- `alu_a` / `alu_b` out M×N signed; `alu_ctrl` out 4: ALU operands and opcode.
- `alu_result` in M×N signed: combinational ALU result, same cycle.
- `y` out M×N signed: block result.
- `y_valid` out 1; `y_ready` in 1: output handshake.

## Operation
- States: IDLE, FETCH, MUL, ACC, OUT.
- IDLE: `start` high latches `taps`/`shamt` and clears k and all accumulators.
  - If `taps` = 0: go to OUT with y = 0.
  - Otherwise: go to FETCH.
- FETCH: drive `x_addr` = `h_addr` = k. Next state MUL.
- MUL: `alu_a` = `x_data`, `alu_b` = `h_data`, `alu_ctrl` = MUL (4'b0010). Register `alu_result` into the product register p. Next state ACC.
- ACC: `alu_a` = p, `alu_b` = `shamt` in every lane, `alu_ctrl` = SARI (4'b0101).
  - Per lane: acc ← sat(acc + `alu_result`); increment k.
  - If k+1 = taps: go to OUT. Otherwise: go to FETCH.
- OUT: `y` = acc, `y_valid` high. On `y_valid && y_ready`: pulse `done`, go to IDLE.
- Arithmetic: the ALU product is the N-bit lane value returned by the ALU; the sequencer does not widen it.
- Saturation: the sum is formed in N+1 bits, then clamped to [-2^(N-1), 2^(N-1)-1].
- `alu_ctrl` = 4'b0000 in IDLE, FETCH and OUT; `alu_a`/`alu_b` = 0 in those states.
- `x_addr`/`h_addr` hold k in all states.

## Timing
- Reset values:
  - state IDLE, k = 0, acc = 0, p = 0.
  - `busy`, `done`, `y_valid` = 0; `y` = 0.
  - `alu_a`, `alu_b`, `alu_ctrl` = 0; `x_addr`, `h_addr` = 0.
- Latency: 3 cycles per tap. `y_valid` first rises 1 + 3·taps cycles after the `start` edge (1 cycle when taps = 0).
- `y` and `y_valid` are stable while `y_ready` is low. A transfer happens in the first cycle where both are high.
- `start` while busy is ignored. `start` in the same cycle as the OUT transfer is ignored; accepted from the next IDLE cycle.
- `rst` mid-block: IDLE on the next edge, all outputs return to reset values, and the partial result is discarded.
- `taps`/`shamt` changes after `start` do not affect the running block.
- `shamt` ≥ N: behaviour is whatever the ALU defines; the sequencer passes the value through unchanged.

## Structure
- Package `fir_vect_pkg`:
  - ALU opcode constants: ALU_MUL = 4'b0010, ALU_SRLI = 4'b0011, ALU_SLLI = 4'b0100, ALU_SARI = 4'b0101, ALU_NOP = 4'b0000.
  - State enum `fir_state_t`.
- Sub-module `sat_add_vect` (parameters N, M): lane-wise signed saturating add, combinational.
- `alu_vect` is instantiated outside this block; this block only drives and reads its ports.

## Test plan
- taps=1, shamt=0, x={10,20,-30,5}, h={2,3,4,-1}, y_ready=1 → y={20,60,-120,-5}; `y_valid` 4 cycles after start; `done` pulses once.
- taps=2, shamt=1, x0=x1={16,16,16,16}, h0=h1={4,4,4,4} → y={64,64,64,64}; `y_valid` at cycle 7.
- taps=3, shamt=0, x={100,-100,50,0}, h={1,1,1,1} for every tap → y={127,-128,127,0}.
- taps=1, `y_ready` low for 5 cycles after `y_valid`; `start` pulsed during the stall → y held constant, `busy` stays high, start ignored, `done` coincides with `y_ready` rising.
- `rst` asserted in the MUL state of tap 1 → next cycle IDLE with all outputs zero; rerunning the scenario-1 stimulus gives scenario-1 results.
- taps=0, start → `y_valid` on the next cycle with y={0,0,0,0}; `alu_ctrl` stays 4'b0000 throughout.
